bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
Multi-digit BCD countdown timer, the decrementing counterpart of the team's decade up-counter.
- Loads a BCD preset and decrements by one on each qualified tick until the value reaches zero.
- Signals expiry with a done pulse; optionally auto-reloads for periodic operation.
- Sits between the prescaler/tick generator and the seven-segment display and interrupt logic.

Parameters:
DIGITS, 4, number of BCD digits (total value width 4*DIGITS)
AUTO_RELOAD, 0, 1 = on expiry reload the latched preset and keep running; 0 = stop in DONE

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
tick  input  1  count-enable pulse, one decrement per cycle it is high while RUN
load  input  1  latch load_val as preset and current value
load_val  input  4*DIGITS  BCD preset, digit 0 in bits [3:0]
start  input  1  begin or resume counting
pause  input  1  suspend counting
count  output  4*DIGITS  current BCD value
busy  output  1  high in RUN
done  output  1  one-cycle pulse on the cycle the value becomes zero
zero  output  1  level, high while count == 0

Behaviour:
Reset and interface
- Reset is rst, synchronous, active-high; clock is clk. All state updates on the posedge of clk.
- Reset values: count=0, preset=0, state=IDLE, busy=0, done=0, zero=1.
- Reset mid-operation aborts the count immediately with the same values.

Load
- Any load_val digit greater than 9 is clamped to 9 on load.
- load is accepted in any state. It sets count and preset, and moves to IDLE.
- load has priority over start, pause and tick in the same cycle.

State machine (IDLE, RUN, PAUSED, DONE)
- IDLE: start and count!=0 -> RUN. start and count==0 -> stay IDLE with no done pulse.
- RUN: pause -> PAUSED. pause has priority over tick, so no decrement occurs that cycle.
- RUN: tick -> decrement.
- PAUSED: start -> RUN. A tick while PAUSED is ignored.
- DONE: start with AUTO_RELOAD=0 and preset!=0 -> reload preset, then RUN. Otherwise DONE holds.
- start while already in RUN is ignored.

Decrement
- BCD borrow chain. Digit 0 always decrements.
- A digit at 0 becomes 9 and borrows from the next digit; otherwise the digit minus 1.
- Digit i decrements only when all lower digits were 0.
- Output is registered; count reflects the decrement one cycle after the tick edge.

Expiry (decrement produces 0)
- done=1 for exactly that cycle. The clock edge that loads count=0 also asserts done.
- AUTO_RELOAD=0: state becomes DONE and busy drops on the same edge.
- AUTO_RELOAD=1: the next tick in RUN loads preset instead of decrementing. done pulses once per period. count shows 0 for the interval between expiry and the next tick.
- A preset of 0 with AUTO_RELOAD=1 stays in IDLE and never runs.

Outputs
- zero is combinational from the registered count.
- busy is registered and equals (state==RUN).
- A value of 0 never underflows to 99..9.

Decomposition:
- Package bcd_timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSED, DONE);
  - BCD_MAX=4'd9;
  - DIGIT_W=4;
  - a function that clamps one digit to 0..9.
- Sub-module bcd_digit_down: single-digit down-counter.
  - Inputs: clk, rst, load, d, dec_in.
  - Outputs: q, borrow_out.
  - borrow_out is combinational and equals dec_in and (q==0).
- DIGITS instances are generated and chained through borrow, with dec_in of digit i+1 = borrow_out of digit i.
- The top level holds the FSM, preset register and done logic.

Test Plan:
1. Reset then idle: rst for 2 cycles -> count=0000, zero=1, busy=0, done=0. start without load -> state IDLE, no done pulse.
2. Borrow chain: load 0x1000, start, 1 tick -> count=0999. A second tick -> 0998, busy=1, done=0.
3. Expiry, AUTO_RELOAD=0: load 0x0003, start, 3 ticks -> counts 0002, 0001, 0000. done high exactly on the third update cycle, busy=0. Further ticks leave count=0000 with no new done.
4. Pause, clamp and priority:
   - load 0x00F5 -> count=0095.
   - start, tick, then pause asserted together with a tick -> count stays 0094 while PAUSED, even over 5 more ticks.
   - start -> RUN, next tick gives 0093.
   - load together with tick -> load value wins.
5. Periodic mode, AUTO_RELOAD=1: load 0x0002, start, 6 ticks -> sequence 1, 0, 2, 1, 0, 2. done pulses on both transitions to 0, and busy stays 1.
6. Reset mid-run: load 0x0500, start, 10 ticks, then rst during a tick -> count=0000, state IDLE, done=0. start without a new load -> stays IDLE.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Force a nibble into the legal BCD range; A..F saturate to 9.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit down-counter with borrow output for chaining.
// Latency: q updates one cycle after load/dec_in; borrow_out is combinational.
// Backpressure: none; load wins over dec_in.
// Ports: clk, rst (sync, active-high); load/d preset the digit;
//        dec_in decrements; q is the digit; borrow_out = dec_in & (q==0).
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               dec_in,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (dec_in) begin
      r_q <= (r_q == '0) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q          = r_q;
  assign borrow_out = dec_in & (r_q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with done pulse and optional auto-reload.
// Latency: count/busy/done registered, valid one cycle after the qualifying input.
// Backpressure: none; load > pause > tick, ticks outside RUN are dropped.
// Ports: clk, rst (sync, active-high); tick, load/load_val, start, pause in;
//        count (BCD, digit 0 in [3:0]), busy (state==RUN), done (1-cycle
//        expiry pulse), zero (count==0) out.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    load,
  input  logic [4*DIGITS-1:0]     load_val,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*DIGITS-1:0]     count,
  output logic                    busy,
  output logic                    done,
  output logic                    zero
);

  localparam int W = DIGITS * DIGIT_W;
  localparam logic [W-1:0] ONE = W'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_preset;
  logic            r_busy;
  logic            r_done;

  logic            w_done_nxt;
  logic            w_dig_load;
  logic [W-1:0]    w_dig_d;
  logic [W-1:0]    w_load_clamped;
  logic [W-1:0]    w_count;
  logic            w_dec;
  logic [DIGITS-1:0] w_dec_in;
  logic [DIGITS-1:0] w_borrow;
  logic            w_zero;
  logic            w_is_one;
  logic            w_msd_borrow_unused;

  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Digit chain: digit i+1 moves only when every lower digit borrows.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign w_dec_in[i] = w_dec;
    end else begin : g_upper
      assign w_dec_in[i] = w_borrow[i-1];
    end

    bcd_digit_down u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (w_dig_load),
      .d          (w_dig_d[i*DIGIT_W +: DIGIT_W]),
      .dec_in     (w_dec_in[i]),
      .q          (w_count[i*DIGIT_W +: DIGIT_W]),
      .borrow_out (w_borrow[i])
    );
  end

  // The top digit can only borrow on an underflow, which the FSM never allows.
  assign w_msd_borrow_unused = w_borrow[DIGITS-1];

  assign w_zero   = (w_count == '0);
  assign w_is_one = (w_count == ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_dig_load  = 1'b0;
    w_dig_d     = r_preset;
    w_dec       = 1'b0;
    w_done_nxt  = 1'b0;

    if (load) begin
      w_dig_load  = 1'b1;
      w_dig_d     = w_load_clamped;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          // A zero count never enters RUN, so no done pulse and no underflow.
          if (start && !w_zero) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            w_state_nxt = PAUSED;
          end else if (tick) begin
            if (w_zero) begin
              // Only reachable in auto-reload mode after expiry: restart the period.
              w_dig_load = 1'b1;
            end else begin
              w_dec = 1'b1;
              if (w_is_one) begin
                w_done_nxt = 1'b1;
                if (!AUTO_RELOAD) begin
                  w_state_nxt = DONE;
                end
              end
            end
          end
        end
        PAUSED: begin
          if (start) begin
            w_state_nxt = RUN;
          end
        end
        DONE: begin
          if (start && !AUTO_RELOAD && (r_preset != '0)) begin
            w_dig_load  = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_preset <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= w_done_nxt;
      if (load) begin
        r_preset <= w_load_clamped;
      end
    end
  end

  assign count = w_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign zero  = w_zero;

endmodule

// File: tb/tb_bcd_down_timer.sv
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tick, load, start, pause;
  logic [15:0] load_val;

  logic [15:0] count0, count1;
  logic        busy0, busy1, done0, done1, zero0, zero1;

  bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(count0), .busy(busy0),
    .done(done0), .zero(zero0)
  );

  bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(count1), .busy(busy1),
    .done(done1), .zero(zero1)
  );

  typedef struct {
    bit          which;
    string       name;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Inputs change on the falling edge, the DUT samples them on the next rising edge.
  task automatic cyc(input logic r, input logic l, input logic [15:0] v,
                     input logic s, input logic p, input logic t);
    @(negedge clk);
    rst = r; load = l; load_val = v; start = s; pause = p; tick = t;
  endtask

  // Expected outputs after the rising edge that follows the last cyc().
  task automatic chk(input bit w, input string n, input logic [15:0] c,
                     input logic b, input logic d);
    exp_t e;
    e.which = w; e.name = n; e.cnt = c; e.busy = b; e.done = d;
    e.zero  = (c == 16'h0000);
    sb_q.push_back(e);
  endtask

  // Monitor: consumes every expectation queued for the edge just taken.
  initial begin : monitor
    exp_t        e;
    logic [15:0] ac;
    logic        ab, ad, az;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        ac = e.which ? count1 : count0;
        ab = e.which ? busy1  : busy0;
        ad = e.which ? done1  : done0;
        az = e.which ? zero1  : zero0;
        checks++;
        if ({ac, ab, ad, az} !== {e.cnt, e.busy, e.done, e.zero}) begin
          failures++;
          $display("FAIL %s dut%0d: got count=%h busy=%b done=%b zero=%b, want count=%h busy=%b done=%b zero=%b",
                   e.name, e.which, ac, ab, ad, az, e.cnt, e.busy, e.done, e.zero);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;

    // 1. reset and idle start with zero count
    cyc(1,0,16'h0,0,0,0);
    cyc(1,0,16'h0,0,0,0);
    chk(0, "reset0", 16'h0000, 0, 0);
    chk(1, "reset1", 16'h0000, 0, 0);
    cyc(0,0,16'h0,1,0,0); chk(0, "start_no_load", 16'h0000, 0, 0);
    cyc(0,0,16'h0,0,0,1); chk(0, "idle_tick",     16'h0000, 0, 0);

    // 2. borrow chain across three digits
    cyc(0,1,16'h1000,0,0,0); chk(0, "load_1000", 16'h1000, 0, 0);
    cyc(0,0,16'h0,1,0,0);    chk(0, "run_1000",  16'h1000, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "borrow",    16'h0999, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "dec_0998",  16'h0998, 1, 0);

    // 3. expiry without reload, then restart from DONE
    cyc(0,1,16'h0003,0,0,0); chk(0, "load_3",   16'h0003, 0, 0);
    cyc(0,0,16'h0,1,0,0);    chk(0, "run_3",    16'h0003, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "exp_2",    16'h0002, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "exp_1",    16'h0001, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "expire",   16'h0000, 0, 1);
    cyc(0,0,16'h0,0,0,1);    chk(0, "no_undfl", 16'h0000, 0, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "no_undfl2",16'h0000, 0, 0);
    cyc(0,0,16'h0,1,0,0);    chk(0, "done_restart", 16'h0003, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "restart_dec",  16'h0002, 1, 0);

    // 4. clamp, pause priority, resume, load priority
    cyc(0,1,16'h00F5,0,0,0); chk(0, "clamp_95", 16'h0095, 0, 0);
    cyc(0,0,16'h0,1,0,0);    chk(0, "run_95",   16'h0095, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "dec_94",   16'h0094, 1, 0);
    cyc(0,0,16'h0,0,1,1);    chk(0, "pause_wins", 16'h0094, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,16'h0,0,0,1);  chk(0, "paused_tick", 16'h0094, 0, 0);
    end
    cyc(0,0,16'h0,1,0,0);    chk(0, "resume",   16'h0094, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "dec_93",   16'h0093, 1, 0);
    cyc(0,1,16'h0042,0,0,1); chk(0, "load_wins",16'h0042, 0, 0);
    cyc(0,1,16'hA0F1,0,0,0); chk(0, "clamp_multi", 16'h9091, 0, 0);

    // 5. periodic mode on the auto-reload instance
    cyc(0,1,16'h0002,0,0,0); chk(1, "ar_load",  16'h0002, 0, 0);
    cyc(0,0,16'h0,1,0,0);    chk(1, "ar_run",   16'h0002, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(1, "ar_1a",    16'h0001, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(1, "ar_0a",    16'h0000, 1, 1);
    cyc(0,0,16'h0,0,0,0);    chk(1, "ar_hold0", 16'h0000, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(1, "ar_2a",    16'h0002, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(1, "ar_1b",    16'h0001, 1, 0);
    cyc(0,0,16'h0,0,0,1);    chk(1, "ar_0b",    16'h0000, 1, 1);
    cyc(0,0,16'h0,0,0,1);    chk(1, "ar_2b",    16'h0002, 1, 0);
    cyc(0,1,16'h0000,0,0,0); chk(1, "ar_load0", 16'h0000, 0, 0);
    cyc(0,0,16'h0,1,0,0);    chk(1, "ar_zero_idle", 16'h0000, 0, 0);

    // 6. reset in the middle of a run
    cyc(0,1,16'h0500,0,0,0); chk(0, "load_500", 16'h0500, 0, 0);
    cyc(0,0,16'h0,1,0,0);
    for (int i = 0; i < 10; i++) cyc(0,0,16'h0,0,0,1);
    chk(0, "after_10", 16'h0490, 1, 0);
    cyc(1,0,16'h0,0,0,1);    chk(0, "mid_rst",  16'h0000, 0, 0);
    cyc(0,0,16'h0,1,0,0);    chk(0, "rst_start",16'h0000, 0, 0);
    cyc(0,0,16'h0,0,0,1);    chk(0, "rst_tick", 16'h0000, 0, 0);

    cyc(0,0,16'h0,0,0,0);
    @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
